clk_enable_nco: RTL and testbench

CLK_ENABLE_NCO -- requirements
Module: clk_enable_nco

---
 rtl/clk_enable_nco.sv | 131 +++++++++++++
 tb/tb_clk_enable_nco.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_nco.sv
// clk_enable_nco: multi-channel numerically controlled clock-enable generator.
// Each channel owns a phase accumulator; while running, the carry out of
// acc + inc becomes a one-cycle tick, giving tick rate f_clk*inc/2^ACC_W.
// While stopped, a rising edge on step produces exactly one tick instead.
// Ticks are plain enables for downstream logic; there is only one clock.
//
// Ports:
//   clk, rst_n        single clock, asynchronous active-low reset
//   run[i]            channel i free-runs its accumulator
//   step[i]           single-step request (rising edge) while run[i]=0
//   sync_all          clears every accumulator (and carry ticks) this edge
//   cfg_we/ch/inc     writes the increment of channel cfg_ch
//   cfg_phase_rst     with cfg_we, also clears that channel's accumulator/tick
//   cnt_clr[i]        clears channel i's tick counter (wins over counting)
//   tick[i]           registered one-cycle tick pulse
//   tick_count        channel i counter at [i*CNT_W +: CNT_W]

module clk_enable_nco_lane #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             sync_all,
    input  logic             phase_rst,
    input  logic             inc_we,
    input  logic [ACC_W-1:0] inc_wdata,
    input  logic             cnt_clr,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             step_q, step_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        acc_d  = acc_q;
        inc_d  = inc_q;
        step_d = step;
        tick_d = 1'b0;
        cnt_d  = cnt_q;
        sum    = {1'b0, acc_q} + {1'b0, inc_q};

        if (run) begin
            acc_d  = sum[ACC_W-1:0];
            tick_d = sum[ACC_W];
        end else begin
            tick_d = step & ~step_q;
        end

        // Clearing the phase kills any carry tick; a step tick survives
        // sync_all but not an explicit per-channel phase reset.
        if (sync_all || phase_rst) begin
            acc_d = '0;
            if (run) tick_d = 1'b0;
        end
        if (phase_rst) tick_d = 1'b0;

        // The add above used the old increment; the new one applies next edge.
        if (inc_we) inc_d = inc_wdata;

        if (cnt_clr)     cnt_d = '0;
        else if (tick_d) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            inc_q  <= '0;
            step_q <= 1'b0;
            tick_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            step_q <= step_d;
            tick_q <= tick_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tick = tick_q;
    assign cnt  = cnt_q;
endmodule

module clk_enable_nco #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 32,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       run,
    input  logic [CHANNELS-1:0]       step,
    input  logic                      sync_all,
    input  logic                      cfg_we,
    input  logic [3:0]                cfg_ch,
    input  logic [ACC_W-1:0]          cfg_inc,
    input  logic                      cfg_phase_rst,
    input  logic [CHANNELS-1:0]       cnt_clr,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS*CNT_W-1:0] tick_count
);
    // Writes to cfg_ch >= CHANNELS match no lane and are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic sel;
        assign sel = cfg_we && (cfg_ch == 4'(i));

        clk_enable_nco_lane #(
            .ACC_W (ACC_W),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .run       (run[i]),
            .step      (step[i]),
            .sync_all  (sync_all),
            .phase_rst (sel && cfg_phase_rst),
            .inc_we    (sel),
            .inc_wdata (cfg_inc),
            .cnt_clr   (cnt_clr[i]),
            .tick      (tick[i]),
            .cnt       (tick_count[i*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_clk_enable_nco.sv
module tb_clk_enable_nco;
    localparam int CH  = 2;
    localparam int AW  = 8;
    localparam int CW  = 4;
    localparam int MOD = 1 << AW;
    localparam int CMOD = 1 << CW;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [CH-1:0]      run, step, cnt_clr;
    logic               sync_all, cfg_we, cfg_phase_rst;
    logic [3:0]         cfg_ch;
    logic [AW-1:0]      cfg_inc;
    logic [CH-1:0]      tick;
    logic [CH*CW-1:0]   tick_count;

    always #5 clk = ~clk;

    clk_enable_nco #(.CHANNELS(CH), .ACC_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .sync_all(sync_all),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
        .cfg_phase_rst(cfg_phase_rst), .cnt_clr(cnt_clr),
        .tick(tick), .tick_count(tick_count)
    );

    typedef struct packed {
        logic [CH-1:0]    tick;
        logic [CH*CW-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int vectors = 0, miscompares = 0;
    int obs0 = 0, obs1 = 0;

    // Reference model: plain integer phase arithmetic per channel.
    int m_acc[CH], m_inc[CH], m_cnt[CH];
    bit m_stq[CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_acc[c] = 0; m_inc[c] = 0; m_cnt[c] = 0; m_stq[c] = 0;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, advance the model, queue the
    // outputs the DUT must show after the coming posedge.
    task automatic cycle(input logic [CH-1:0] r, input logic [CH-1:0] s,
                         input bit sy, input bit we, input int ch,
                         input int inc, input bit pr, input logic [CH-1:0] cc);
        exp_t e;
        bit   t;
        bit   hit;
        @(negedge clk);
        run = r; step = s; sync_all = sy; cfg_we = we; cfg_ch = 4'(ch);
        cfg_inc = AW'(inc); cfg_phase_rst = pr; cnt_clr = cc;
        e = '0;
        for (int c = 0; c < CH; c++) begin
            hit = we && pr && (ch == c);
            if (r[c]) begin
                if (sy || hit) begin
                    m_acc[c] = 0; t = 0;
                end else begin
                    t = (m_acc[c] + m_inc[c]) >= MOD;
                    m_acc[c] = (m_acc[c] + m_inc[c]) % MOD;
                end
            end else begin
                t = s[c] && !m_stq[c];
                if (sy || hit) m_acc[c] = 0;
                if (hit) t = 0;
            end
            m_stq[c] = s[c];
            if (cc[c])  m_cnt[c] = 0;
            else if (t) m_cnt[c] = (m_cnt[c] + 1) % CMOD;
            e.tick[c] = t;
            e.cnt[c*CW +: CW] = CW'(m_cnt[c]);
        end
        if (we && ch < CH) m_inc[ch] = inc;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n, input logic [CH-1:0] r);
        for (int k = 0; k < n; k++) cycle(r, '0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 10) begin
            @(posedge clk); #2; n++;
        end
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if (tick !== e.tick || tick_count !== e.cnt) begin
                miscompares++;
                $display("FAIL vec%0d: tick=%b cnt=%h, expected tick=%b cnt=%h",
                         vectors, tick, tick_count, e.tick, e.cnt);
            end
            if (tick[0]) obs0++;
            if (tick[1]) obs1++;
        end
    end

    initial begin
        rst_n = 1'b0; run = '0; step = '0; sync_all = 0; cfg_we = 0;
        cfg_ch = '0; cfg_inc = '0; cfg_phase_rst = 0; cnt_clr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_tick", int'(tick), 0);
        check("reset_cnt", int'(tick_count), 0);
        @(negedge clk); rst_n = 1'b1;

        // inc=64 from acc=0: ticks on edges 4, 8, 12
        cycle('0, '0, 0, 1, 0, 64, 1, '0);
        idle(12, 2'b01);
        drain();
        check("inc64_count", int'(tick_count[CW-1:0]), 3);

        // inc=255: 255 ticks in 256 edges; inc=0: none
        cycle('0, '0, 0, 1, 0, 255, 1, 2'b01);
        drain(); obs0 = 0;
        idle(256, 2'b01);
        drain();
        check("inc255_ticks", obs0, 255);
        cycle('0, '0, 0, 1, 0, 0, 1, '0);
        drain(); obs0 = 0;
        idle(256, 2'b01);
        drain();
        check("inc0_ticks", obs0, 0);

        // single step: held high 5 cycles -> one tick; ignored while running
        obs0 = 0;
        for (int k = 0; k < 5; k++) cycle('0, 2'b01, 0, 0, 0, 0, 0, '0);
        idle(3, '0);
        drain();
        check("step_once", obs0, 1);
        obs0 = 0;
        for (int k = 0; k < 6; k++) cycle(2'b01, 2'(k % 2), 0, 0, 0, 0, 0, '0);
        drain();
        check("step_while_run", obs0, 0);

        // sync_all with simultaneous inc write on ch1
        cycle('0, '0, 0, 1, 1, 96, 1, '0);
        idle(2, 2'b10);
        cycle(2'b10, '0, 1, 1, 1, 32, 0, '0);
        drain(); obs1 = 0;
        idle(7, 2'b10);
        drain();
        check("sync_no_early", obs1, 0);
        idle(1, 2'b10);
        drain();
        check("sync_8th", obs1, 1);

        // counter wrap at 17 ticks, clear on a tick edge, out-of-range write
        cycle('0, '0, 0, 1, 0, 128, 1, 2'b01);
        idle(34, 2'b01);
        drain();
        check("cnt_wrap", int'(tick_count[CW-1:0]), 1);
        cycle(2'b01, '0, 0, 0, 0, 0, 0, 2'b01);
        cycle(2'b01, '0, 0, 0, 0, 0, 0, '0);
        cycle(2'b01, '0, 0, 1, CH, 1, 1, '0);
        idle(4, 2'b01);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            cycle(2'($urandom), 2'($urandom), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3),
                  int'($urandom_range(0, 255)), $urandom_range(0, 2) == 0,
                  ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00);
        end
        drain();

        // asynchronous reset mid-run
        cycle('0, '0, 0, 1, 0, 64, 1, '0);
        cycle('0, '0, 0, 1, 1, 80, 1, '0);
        idle(6, 2'b11);
        drain();
        #1 rst_n = 1'b0;
        #1;
        check("arst_tick", int'(tick), 0);
        check("arst_cnt", int'(tick_count), 0);
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        obs0 = 0; obs1 = 0;
        idle(20, 2'b11);
        drain();
        check("post_rst_ticks", obs0 + obs1, 0);
        cycle('0, '0, 0, 1, 0, 64, 0, '0);
        idle(4, 2'b01);
        drain();
        check("post_rst_first", obs0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
